// File: rtl/hrange_ext.sv
// Range generator: emits range(base, limit, step) one signed element per accepted cycle.
// Ports: _clock/_reset(async low), _start/base/limit/step in, _wait stall, _0/_valid/_ready out; HRANGE_EXT_COUNT_EN adds _count.
module hrange_ext #(
  parameter int WIDTH = 32
) (
  input  logic             _clock,
  input  logic             _reset,
  input  logic             _start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] step,
  input  logic             _wait,
  output logic [WIDTH-1:0] _0,
  output logic             _valid,
  output logic             _ready
`ifdef HRANGE_EXT_COUNT_EN
  ,
  output logic [WIDTH-1:0] _count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_EMIT
  } state_t;

  state_t           r_state;
  state_t           w_state_n;
  logic [WIDTH-1:0] r_cur;
  logic [WIDTH-1:0] r_lim;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH:0]   w_cur_x;
  logic [WIDTH:0]   w_lim_x;
  logic [WIDTH:0]   w_stp_x;
  logic [WIDTH:0]   w_nxt;
  logic             w_load;
  logic             w_adv;
  logic             w_cons;

  // Continuation test in WIDTH+1 bits so an overflowed
  // successor can never look like it is still in range.
  function automatic logic f_cont(
    input logic [WIDTH:0] x,
    input logic [WIDTH:0] lim,
    input logic [WIDTH:0] stp
  );
    logic pos;
    logic neg;
    pos = !stp[WIDTH] && (|stp);
    neg = stp[WIDTH];
    f_cont = (pos && ($signed(x) < $signed(lim)))
          || (neg && ($signed(x) > $signed(lim)));
  endfunction

  assign w_cur_x = {r_cur[WIDTH-1], r_cur};
  assign w_lim_x = {r_lim[WIDTH-1], r_lim};
  assign w_stp_x = {r_step[WIDTH-1], r_step};
  assign w_nxt   = w_cur_x + w_stp_x;

  always_comb begin
    w_state_n = r_state;
    w_load    = 1'b0;
    w_adv     = 1'b0;
    w_cons    = 1'b0;
    _valid    = 1'b0;
    _ready    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        _ready = 1'b1;
        if (_start) begin
          w_load    = 1'b1;
          w_state_n = S_CHECK;
        end
      end
      S_CHECK: begin
        if (f_cont(w_cur_x, w_lim_x, w_stp_x))
          w_state_n = S_EMIT;
        else
          w_state_n = S_IDLE;
      end
      S_EMIT: begin
        _valid = 1'b1;
        if (!_wait) begin
          w_cons = 1'b1;
          if (f_cont(w_nxt, w_lim_x, w_stp_x))
            w_adv = 1'b1;
          else
            w_state_n = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      r_state <= S_IDLE;
      r_cur   <= '0;
      r_lim   <= '0;
      r_step  <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_load) begin
        r_cur  <= base;
        r_lim  <= limit;
        r_step <= step;
      end else if (w_adv) begin
        r_cur <= w_nxt[WIDTH-1:0];
      end
    end
  end

  assign _0 = r_cur;

`ifdef HRANGE_EXT_COUNT_EN
  logic [WIDTH-1:0] r_count;

  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset)
      r_count <= '0;
    else if (w_load)
      r_count <= '0;
    else if (w_cons)
      r_count <= r_count + 1'b1;
  end

  assign _count = r_count;
`endif

endmodule

// File: tb/tb_hrange_ext.sv
// Testbench for hrange_ext (WIDTH=8): scoreboard of model elements vs consumed outputs.
// Covers reset, basic, negative step, empty/zero step, backpressure, overflow, ignored start, abort.
module tb_hrange_ext;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] b_in;
  logic [7:0] l_in;
  logic [7:0] s_in;
  logic       wt;
  logic [7:0] q;
  logic       vld;
  logic       rdy;
`ifdef HRANGE_EXT_COUNT_EN
  logic [7:0] cnt;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] vq[$];

  hrange_ext #(.WIDTH(8)) dut (
    ._clock(clk),
    ._reset(rst_n),
    ._start(start),
    .base(b_in),
    .limit(l_in),
    .step(s_in),
    ._wait(wt),
    ._0(q),
    ._valid(vld),
    ._ready(rdy)
`ifdef HRANGE_EXT_COUNT_EN
    ,
    ._count(cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_model(input int b, input int l, input int s);
    longint x;
    x = b;
    exp_q.delete();
    if (s != 0)
      while ((s > 0 && x < l) || (s < 0 && x > l)) begin
        exp_q.push_back(x[7:0]);
        x += s;
      end
  endtask

  task automatic run_seq(input int b, input int l, input int s,
                         input logic [31:0] wmask,
                         input logic [31:0] smask,
                         output int first, output int rk);
    int bv;
    int lv;
    int sv;
    bv = b;
    lv = l;
    sv = s;
    got_q.delete();
    vq.delete();
    @(negedge clk);
    b_in  = bv[7:0];
    l_in  = lv[7:0];
    s_in  = sv[7:0];
    start = 1'b1;
    wt    = 1'b0;
    @(negedge clk);
    start = 1'b0;
    b_in  = 8'($urandom);
    l_in  = 8'($urandom);
    s_in  = 8'($urandom);
    first = -1;
    rk    = -1;
    for (int k = 0; k < 600 && rk < 0; k++) begin
      if (k > 0) @(negedge clk);
      wt    = (k < 32) ? wmask[k] : 1'b0;
      start = (k < 32) ? smask[k] : 1'b0;
      if (vld) begin
        vq.push_back(q);
        if (first < 0) first = k;
        if (!wt) got_q.push_back(q);
      end
      if (rdy) rk = k;
    end
    start = 1'b0;
    wt    = 1'b0;
    if (rk < 0) begin
      checks++;
      failures++;
      $display("FAIL timeout got=no_ready exp=ready");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    wt    = 1'b0;
    b_in  = '0;
    l_in  = '0;
    s_in  = '0;
    #2;
    checks++;
    if (rdy !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1", rdy);
    end
    checks++;
    if (vld !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b exp=0", vld);
    end
    checks++;
    if (q !== 8'd0) begin
      failures++;
      $display("FAIL reset_q got=%0d exp=0", q);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic(input string nm, input int b, input int l,
                            input int s, input logic [31:0] smask);
    int f;
    int r;
    int n;
    logic [7:0] e;
    logic [7:0] g;
    push_model(b, l, s);
    n = exp_q.size();
    run_seq(b, l, s, 32'h0, smask, f, r);
    checks++;
    if (got_q.size() != n) begin
      failures++;
      $display("FAIL %s_len got=%0d exp=%0d", nm, got_q.size(), n);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL %s_elem got=%0d exp=%0d", nm, $signed(g), $signed(e));
      end
    end
    checks++;
    if (f !== ((n > 0) ? 1 : -1)) begin
      failures++;
      $display("FAIL %s_first got=%0d exp=%0d", nm, f, (n > 0) ? 1 : -1);
    end
    checks++;
    if (r !== ((n > 0) ? n + 1 : 1)) begin
      failures++;
      $display("FAIL %s_done got=%0d exp=%0d", nm, r, (n > 0) ? n + 1 : 1);
    end
`ifdef HRANGE_EXT_COUNT_EN
    checks++;
    if (cnt !== 8'(n)) begin
      failures++;
      $display("FAIL %s_count got=%0d exp=%0d", nm, cnt, n);
    end
`endif
  endtask

  task automatic test_backpressure();
    int f;
    int r;
    logic [7:0] e;
    logic [7:0] g;
    // element 1 is presented at k=2 and stalled for k=2..4
    run_seq(0, 3, 1, 32'h1C, 32'h0, f, r);
    exp_q.delete();
    exp_q.push_back(8'd0);
    repeat (4) exp_q.push_back(8'd1);
    exp_q.push_back(8'd2);
    checks++;
    if (vq.size() != exp_q.size()) begin
      failures++;
      $display("FAIL bp_len got=%0d exp=%0d", vq.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && vq.size() > 0) begin
      e = exp_q.pop_front();
      g = vq.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL bp_elem got=%0d exp=%0d", g, e);
      end
    end
    checks++;
    if (got_q.size() != 3) begin
      failures++;
      $display("FAIL bp_consumed got=%0d exp=3", got_q.size());
    end
    checks++;
    if (r !== 7) begin
      failures++;
      $display("FAIL bp_done got=%0d exp=7", r);
    end
  endtask

  task automatic test_abort();
    @(negedge clk);
    b_in  = 8'd0;
    l_in  = 8'd100;
    s_in  = 8'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (vld !== 1'b0) begin
      failures++;
      $display("FAIL abort_valid got=%b exp=0", vld);
    end
    checks++;
    if (rdy !== 1'b1) begin
      failures++;
      $display("FAIL abort_ready got=%b exp=1", rdy);
    end
`ifdef HRANGE_EXT_COUNT_EN
    checks++;
    if (cnt !== 8'd0) begin
      failures++;
      $display("FAIL abort_count got=%0d exp=0", cnt);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    test_basic("fresh", 3, 9, 2, 32'h0);
  endtask

  task automatic test_random();
    int b;
    int l;
    int s;
    for (int i = 0; i < 3; i++) begin
      b = int'($urandom_range(255)) - 128;
      l = int'($urandom_range(255)) - 128;
      s = int'($urandom_range(8)) - 4;
      test_basic("rand", b, l, s, 32'h0);
    end
  endtask

  initial begin
    test_reset();
    test_basic("basic", 0, 10, 2, 32'h0);
    test_basic("neg", 5, -3, -3, 32'h0);
    test_basic("empty", 7, 7, 1, 32'h0);
    test_basic("zero", 5, 9, 0, 32'h0);
    test_backpressure();
    test_basic("ovf_pos", 125, 127, 3, 32'h0);
    test_basic("ovf_neg", -126, -128, -3, 32'h0);
    test_basic("busy_start", 0, 10, 2, 32'h0C);
    test_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hrange_ext.md
Name: hrange_ext

Overview:
- Parametrised successor to the single-width range generator.
- Emits the Python-style sequence range(base, limit, step) as one signed element per accepted cycle on _0.
- Generalised to a WIDTH-bit datapath. Adds negative steps, overflow-safe termination, a zero-step guard and consumer backpressure.
- Sits beneath generated function-call wrappers as a leaf generator. The caller pulses _start and drains elements via _valid/_wait.

Parameters:
- WIDTH, 32, bit width of base, limit, step and _0 (signed two's complement, minimum 2).

Ports:
- _clock  input  1  single system clock, rising-edge active.
- _reset  input  1  asynchronous, active-low reset.
- _start  input  1  begin a new sequence; sampled only while _ready=1.
- base  input  WIDTH  signed first value; sampled on accepted _start.
- limit  input  WIDTH  signed exclusive bound; sampled on accepted _start.
- step  input  WIDTH  signed increment; sampled on accepted _start.
- _wait  input  1  consumer stall; while high, the current element is held.
- _0  output  WIDTH  signed current element; meaningful only when _valid=1.
- _valid  output  1  _0 carries an element.
- _ready  output  1  block is idle and will accept _start.

Behaviour:
- Reset (_reset low, asynchronous, takes effect immediately):
  - State goes to IDLE.
  - Outputs: _ready=1, _valid=0, _0=0.
  - Internal cur/limit/step registers are cleared.
- Reset asserted mid-sequence aborts it; no further elements are produced. Release is synchronised by the integrator.
- States:
  - IDLE: _ready=1, _valid=0. On a rising edge with _start=1, latch base/limit/step, then go to CHECK.
  - CHECK: one cycle, _ready=0, _valid=0. Evaluate the first element with the continuation predicate cont(x):
    - cont(x) is true if step>0 and x<limit, or if step<0 and x>limit.
    - If step=0, cont is false; the guard prevents an infinite sequence.
    - If cont(base) is true, go to EMIT with _0=base; otherwise go to IDLE.
  - EMIT: _valid=1, _ready=0.
    - If _wait=1: hold _0, stay in EMIT.
    - If _wait=0 (element consumed): compute nxt = cur + step in WIDTH+1 bits, sign-extended.
      - If cont(nxt) holds (compared in WIDTH+1 bits), set _0 = nxt[WIDTH-1:0] and stay in EMIT.
      - Otherwise go to IDLE.
- Latency: the first element appears on _0 two rising edges after _start is accepted. Elements follow back-to-back, one per cycle, while _wait=0.
- Completion: after the last consumed element, _valid=0 and _ready=1 from the next cycle.
- Empty range (cont(base) false, or step=0):
  - Exactly one CHECK cycle with _ready=0, _valid=0, then IDLE.
  - _valid is never asserted.
- Overflow: nxt exceeding the WIDTH range always fails cont, because limit is representable. There is no wrap-around emission; e.g. base=2^(WIDTH-1)-2, step=3 emits one element.
- _start while busy (CHECK/EMIT) is ignored. Inputs base/limit/step may change freely after acceptance.
- _wait is ignored outside EMIT.
- _0 holds its last value in IDLE; it is not cleared.

Optional Feature:
- Macro: HRANGE_EXT_COUNT_EN.
- Defined:
  - Adds output port _count [WIDTH-1:0], unsigned.
  - _count clears to 0 on reset and on accepted _start.
  - It increments on every consumed element (EMIT with _wait=0).
  - It holds the total after completion until the next _start.
- Not defined: port absent, no counter logic. All other behaviour is identical.

Test Plan:
- Basic: base=0, limit=10, step=2, _wait=0 -> _valid high for 5 consecutive cycles with _0=0,2,4,6,8, then _ready=1; _count=5 if enabled.
- Negative step: base=5, limit=-3, step=-3 -> _0=5,2,-1, then done.
- Empty/zero guard:
  - base=7, limit=7, step=1 -> no _valid, _ready back high 2 cycles after _start.
  - step=0 -> same response.
- Backpressure and overflow:
  - base=0, limit=3, step=1, _wait high for 3 cycles while _0=1 -> _0 holds 1 those cycles; sequence still 0,1,2 with no duplicates or drops.
  - WIDTH=8, base=125, limit=127, step=3 -> single element 125, no wrap to -128.
- Abort/ignore:
  - _start pulsed during EMIT -> ignored, original sequence completes.
  - _reset low mid-sequence -> _valid=0, _ready=1 immediately (asynchronous); next _start runs a fresh sequence correctly.
